// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access
//   MEM stage of the 16-bit MIPS pipeline. It takes the Execute stage's ALU
//   result and zero flag. Loads and stores go to a word-addressed data memory
//   that adds WAIT_CYCLES extra cycles of latency. The stage holds stall high
//   while an access is pending. It registers the ALU result, the load data and
//   the branch decision for the write-back and fetch stages.
//
// Parameters
//   DATA_W       data / word width
//   ADDR_W       word-address bits; memory depth = 2**ADDR_W words
//   WAIT_CYCLES  extra wait cycles per memory access (0..15)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   inValid    in   Execute outputs valid this cycle
//   aluOut     in   ALU result; its low ADDR_W bits address the memory
//   zero       in   ALU zero flag
//   writeData  in   store data
//   memRead    in   load request
//   memWrite   in   store request (wins when memRead is also set)
//   branch     in   instruction is a conditional branch
//   stall      out  upstream must hold its outputs this cycle
//   outValid   out  one-cycle pulse: result registers updated
//   aluResult  out  registered ALU result
//   readData   out  registered load data
//   pcSrc      out  branch taken; only asserted together with outValid
// -----------------------------------------------------------------------------
module memory_access #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inValid,
  input  logic [DATA_W-1:0] aluOut,
  input  logic              zero,
  input  logic [DATA_W-1:0] writeData,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              branch,
  output logic              stall,
  output logic              outValid,
  output logic [DATA_W-1:0] aluResult,
  output logic [DATA_W-1:0] readData,
  output logic              pcSrc
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);
  localparam int         DEPTH    = 1 << ADDR_W;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              accept, complete, alu_pass, stall_raw;
  logic              memop;

  // Operation captured in the accept cycle; upstream is free to change after.
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] alu_reg;
  logic              load_reg, store_reg, taken_reg;

  logic              out_valid_reg, pc_src_reg;
  logic [DATA_W-1:0] alu_result_reg, read_data_reg;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  assign memop    = memRead | memWrite;
  assign alu_pass = (state_reg == IDLE) && inValid && !memop;

  // Next-state logic. In WAIT the inputs are ignored. When cnt reaches zero,
  // the access completes at the end of that cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    complete   = 1'b0;
    stall_raw  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (inValid && memop) begin
          accept     = 1'b1;
          stall_raw  = 1'b1;
          state_next = WAIT;
          cnt_next   = WAIT_CNT;
        end
      end
      WAIT: begin
        if (cnt_reg != 4'd0) begin
          stall_raw = 1'b1;
          cnt_next  = cnt_reg - 4'd1;
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset overrides any pending request toward upstream.
  assign stall = stall_raw && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_reg  <= aluOut[ADDR_W-1:0];
      wdata_reg <= writeData;
      alu_reg   <= aluOut;
      store_reg <= memWrite;
      load_reg  <= memRead && !memWrite;
      taken_reg <= branch && zero;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg  <= 1'b0;
      pc_src_reg     <= 1'b0;
      alu_result_reg <= '0;
    end else if (complete) begin
      out_valid_reg  <= 1'b1;
      pc_src_reg     <= taken_reg;
      alu_result_reg <= alu_reg;
    end else if (alu_pass) begin
      out_valid_reg  <= 1'b1;
      pc_src_reg     <= branch && zero;
      alu_result_reg <= aluOut;
    end else begin
      out_valid_reg  <= 1'b0;
      pc_src_reg     <= 1'b0;
    end
  end

  // Registered memory read. readData holds unless a load completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_reg <= '0;
    end else if (complete && load_reg) begin
      read_data_reg <= mem[addr_reg];
    end
  end

  // Memory contents survive reset. A store aborted by reset is never written.
  always_ff @(posedge clk) begin
    if (!reset && complete && store_reg) begin
      mem[addr_reg] <= wdata_reg;
    end
  end

  assign outValid  = out_valid_reg;
  assign pcSrc     = pc_src_reg;
  assign aluResult = alu_result_reg;
  assign readData  = read_data_reg;

endmodule

// File: tb/tb_memory_access.sv
// -----------------------------------------------------------------------------
// tb_memory_access
//   Drives two memory_access instances: index 0 with WAIT_CYCLES=2 and index 1
//   with WAIT_CYCLES=0. A transaction-level model checks both instances on
//   every cycle. Directed steps with hand-computed values pin the model.
//   Randomized traffic follows, and each instance runs it with its own
//   stall handshake.
// -----------------------------------------------------------------------------
module tb_memory_access;

  typedef struct packed {
    logic        iv;
    logic        mr;
    logic        mw;
    logic        br;
    logic        zr;
    logic [15:0] ao;
    logic [15:0] wd;
  } op_t;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        iv  [2];
  logic        zr  [2];
  logic        mr  [2];
  logic        mw  [2];
  logic        br  [2];
  logic [15:0] ao  [2];
  logic [15:0] wd  [2];
  logic        st  [2];
  logic        ov  [2];
  logic        pc  [2];
  logic [15:0] ar  [2];
  logic [15:0] rd  [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    memory_access #(
      .DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(gi == 0 ? 2 : 0)
    ) u_dut (
      .clk(clk), .reset(rst[gi]), .inValid(iv[gi]), .aluOut(ao[gi]),
      .zero(zr[gi]), .writeData(wd[gi]), .memRead(mr[gi]), .memWrite(mw[gi]),
      .branch(br[gi]), .stall(st[gi]), .outValid(ov[gi]), .aluResult(ar[gi]),
      .readData(rd[gi]), .pcSrc(pc[gi])
    );
  end

  task automatic chk1(string nm, int i, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%b want=%b t=%0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic chk16(string nm, int i, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  function automatic op_t mk(logic v, logic r, logic w, logic b, logic z,
                             logic [15:0] a, logic [15:0] d);
    op_t o;
    o.iv = v; o.mr = r; o.mw = w; o.br = b; o.zr = z; o.ao = a; o.wd = d;
    return o;
  endfunction

  task automatic present(int i, op_t o);
    iv[i] = o.iv; mr[i] = o.mr; mw[i] = o.mw; br[i] = o.br;
    zr[i] = o.zr; ao[i] = o.ao; wd[i] = o.wd;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Each instance has at most one outstanding memory
  // operation. An operation accepted in cycle T finishes at the edge that ends
  // cycle T+W+1, and stall is high in every cycle before that. Outputs are
  // compared against the values the model committed at the previous edge.
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  bit          armed   [2];
  bit          pend    [2];
  int          done_at [2];
  op_t         pop     [2];
  logic [15:0] mm      [2][256];
  logic        e_ov    [2];
  logic        e_pc    [2];
  logic [15:0] e_ar    [2];
  logic [15:0] e_rd    [2];

  initial begin
    logic es;
    int   wc;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        wc = (i == 0) ? 2 : 0;
        if (rst[i])      es = 1'b0;
        else if (pend[i]) es = (cyc < done_at[i]);
        else             es = iv[i] & (mr[i] | mw[i]);
        if (armed[i]) begin
          chk1("outValid", i, ov[i], e_ov[i]);
          chk1("pcSrc", i, pc[i], e_pc[i]);
          chk16("aluResult", i, ar[i], e_ar[i]);
          chk16("readData", i, rd[i], e_rd[i]);
          chk1("stall", i, st[i], es);
        end
        if (rst[i]) begin
          armed[i] = 1'b1;
          pend[i]  = 1'b0;
          e_ov[i] = 1'b0; e_pc[i] = 1'b0; e_ar[i] = 16'h0; e_rd[i] = 16'h0;
        end else if (pend[i] && cyc == done_at[i]) begin
          if (pop[i].mw)      mm[i][pop[i].ao[7:0]] = pop[i].wd;
          else if (pop[i].mr) e_rd[i] = mm[i][pop[i].ao[7:0]];
          e_ar[i] = pop[i].ao;
          e_pc[i] = pop[i].br & pop[i].zr;
          e_ov[i] = 1'b1;
          pend[i] = 1'b0;
        end else if (pend[i]) begin
          e_ov[i] = 1'b0; e_pc[i] = 1'b0;
        end else if (iv[i] && (mr[i] || mw[i])) begin
          pend[i]    = 1'b1;
          pop[i]     = mk(iv[i], mr[i], mw[i], br[i], zr[i], ao[i], wd[i]);
          done_at[i] = cyc + wc + 1;
          e_ov[i] = 1'b0; e_pc[i] = 1'b0;
        end else if (iv[i]) begin
          e_ar[i] = ao[i];
          e_pc[i] = br[i] & zr[i];
          e_ov[i] = 1'b1;
        end else begin
          e_ov[i] = 1'b0; e_pc[i] = 1'b0;
        end
      end
    end
  end

  // Present one instruction and hold it until a cycle ends with stall low. The
  // task returns one cycle after that, when the result registers are visible.
  task automatic do_op(int i, op_t o, output int nst);
    bit done;
    present(i, o);
    nst  = 0;
    done = 1'b0;
    for (int g = 0; g < 40 && !done; g++) begin
      @(negedge clk);
      if (st[i]) nst++;
      else       done = 1'b1;
      @(posedge clk); #1;
    end
    present(i, mk(0, 0, 0, 0, 0, 16'h0, 16'h0));
    if (!done) chk1("handshake_timeout", i, 1'b0, 1'b1);
  endtask

  op_t prog [$];

  initial begin
    int  n, ws;
    int  p   [2];
    bit  adv [2];
    op_t idle;
    logic [15:0] a;
    idle = mk(0, 0, 0, 0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      present(i, idle);
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk16("reset_aluResult", 0, ar[0], 16'h0);
    chk1("reset_outValid", 1, ov[1], 1'b0);

    // Directed behaviour on both instances with hand-computed results
    for (int i = 0; i < 2; i++) begin
      ws = (i == 0) ? 3 : 1;
      do_op(i, mk(1, 0, 1, 0, 0, 16'h0005, 16'h1234), n);
      chk16("store_stall_cycles", i, 16'(n), 16'(ws));
      chk1("store_outValid", i, ov[i], 1'b1);
      do_op(i, mk(1, 1, 0, 0, 0, 16'h0005, 16'h0), n);
      chk16("load_stall_cycles", i, 16'(n), 16'(ws));
      chk1("load_outValid", i, ov[i], 1'b1);
      chk16("load_data", i, rd[i], 16'h1234);
      do_op(i, mk(1, 0, 0, 0, 0, 16'hBEEF, 16'h0), n);
      chk16("alu_stall_cycles", i, 16'(n), 16'd0);
      chk16("alu_result", i, ar[i], 16'hBEEF);
      chk1("alu_outValid", i, ov[i], 1'b1);
      do_op(i, mk(1, 0, 0, 1, 1, 16'h0011, 16'h0), n);
      chk1("branch_taken", i, pc[i], 1'b1);
      @(posedge clk); #1;
      chk1("branch_pulse_end", i, pc[i], 1'b0);
      chk1("branch_ov_end", i, ov[i], 1'b0);
      do_op(i, mk(1, 0, 0, 1, 0, 16'h0011, 16'h0), n);
      chk1("branch_not_taken", i, pc[i], 1'b0);
      chk1("branch_nt_ov", i, ov[i], 1'b1);
      do_op(i, mk(1, 1, 1, 0, 0, 16'h0105, 16'hAAAA), n);
      chk16("both_set_rd_holds", i, rd[i], 16'h1234);
      do_op(i, mk(1, 1, 0, 0, 0, 16'h0005, 16'h0), n);
      chk16("wrap_load", i, rd[i], 16'hAAAA);
    end

    // Reset in the last wait cycle (cnt=1) aborts the pending store
    do_op(0, mk(1, 0, 1, 0, 0, 16'h0007, 16'h0777), n);
    present(0, mk(1, 0, 1, 0, 0, 16'h0007, 16'h5555));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    #1;
    chk1("stall_in_reset", 0, st[0], 1'b0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    present(0, idle);
    chk1("abort_ov", 0, ov[0], 1'b0);
    chk16("abort_ar", 0, ar[0], 16'h0);
    chk16("abort_rd", 0, rd[0], 16'h0);
    chk1("abort_pc", 0, pc[0], 1'b0);
    chk1("abort_stall", 0, st[0], 1'b0);
    do_op(0, mk(1, 1, 0, 0, 0, 16'h0007, 16'h0), n);
    chk16("abort_no_write", 0, rd[0], 16'h0777);

    // Random traffic: initialise words 0..15 first, then mixed operations
    for (int k = 0; k < 16; k++)
      prog.push_back(mk(1, 0, 1, 0, 0, {8'($urandom), 8'(k)}, 16'($urandom)));
    for (int k = 0; k < 300; k++) begin
      a = {8'($urandom), 4'h0, 4'($urandom)};
      case ($urandom_range(0, 9))
        0, 1, 2: prog.push_back(mk(1, 1, 0, 1'($urandom), 1'($urandom), a, 16'($urandom)));
        3, 4, 5: prog.push_back(mk(1, 0, 1, 1'($urandom), 1'($urandom), a, 16'($urandom)));
        6:       prog.push_back(mk(1, 1, 1, 1'($urandom), 1'($urandom), a, 16'($urandom)));
        7, 8:    prog.push_back(mk(1, 0, 0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom)));
        default: prog.push_back(idle);
      endcase
    end
    for (int i = 0; i < 2; i++) begin
      present(i, prog[0]);
      p[i] = 1;
    end
    for (int c = 0; c < 5000 && (p[0] <= prog.size() || p[1] <= prog.size()); c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) adv[i] = !st[i];
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (adv[i] && p[i] <= prog.size()) begin
          if (p[i] < prog.size()) present(i, prog[p[i]]);
          else                    present(i, idle);
          p[i]++;
        end
      end
    end
    for (int i = 0; i < 2; i++)
      chk16("random_progress", i, 16'(p[i]), 16'(prog.size() + 1));
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
